// File: rtl/corectrl_pkg.sv
// Core-control constants: branch funct3 encodings and the 2-bit predictor counter type.
package corectrl;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] CNT_MAX = 2'b11;
    localparam logic [1:0] CNT_MIN = 2'b00;

    typedef logic [1:0] bht_cnt_t;
endpackage

// File: rtl/eei_pkg.sv
// Execution-environment basics shared by the core: native data width and its word type.
package eei;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 32;

    typedef logic [XLEN-1:0]  UIntX;
    typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/br_cond.sv
// Combinational branch-condition evaluator: resolves direction and flags unsupported funct3.
module br_cond
    import corectrl::*;
#(
    parameter int unsigned XLEN = eei::XLEN
) (
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_op1,
    input  logic [XLEN-1:0] i_op2,
    output logic            o_take_c,
    output logic            o_illegal_c
);

    always_comb begin
        o_take_c    = 1'b0;
        o_illegal_c = 1'b0;
        case (i_funct3)
            F3_BEQ:  o_take_c = (i_op1 == i_op2);
            F3_BNE:  o_take_c = (i_op1 != i_op2);
            F3_BLT:  o_take_c = ($signed(i_op1) <  $signed(i_op2));
            F3_BGE:  o_take_c = ($signed(i_op1) >= $signed(i_op2));
            F3_BLTU: o_take_c = (i_op1 <  i_op2);
            F3_BGEU: o_take_c = (i_op1 >= i_op2);
            default: o_illegal_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/brunit_pipe.sv
// Single-stage branch resolution unit with a 2-bit bimodal predictor table and event counters.
// Results are registered behind a valid/ready handshake; flush discards the held result.
module brunit_pipe
    import corectrl::*;
#(
    parameter int unsigned XLEN        = eei::XLEN,
    parameter int unsigned BHT_ENTRIES = 64,
    parameter logic [1:0]  INIT_CNT    = 2'b01
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_op1,
    input  logic [XLEN-1:0] in_op2,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_pred_take,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_take,
    output logic            out_mispredict,
    output logic            out_illegal,
    output logic [XLEN-1:0] out_target,
    input  logic            flush,
    input  logic [XLEN-1:0] pred_pc,
    output logic            pred_take,
    output logic [31:0]     cnt_branches,
    output logic [31:0]     cnt_mispred
);

    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);
    localparam int unsigned CNT_W = 32;

    logic                   r_valid;
    logic                   r_take;
    logic                   r_mispredict;
    logic                   r_illegal;
    logic [XLEN-1:0]        r_target;
    logic [CNT_W-1:0]       r_cnt_branches;
    logic [CNT_W-1:0]       r_cnt_mispred;
    bht_cnt_t               r_bht [BHT_ENTRIES];

    logic                   w_take;
    logic                   w_illegal;
    logic                   w_accept;
    logic                   w_update;
    logic                   w_mispredict;
    logic [XLEN-1:0]        w_target;
    logic [IDX_W-1:0]       w_update_idx;
    logic [IDX_W-1:0]       w_lookup_idx;
    bht_cnt_t               w_bht_cur;
    bht_cnt_t               w_bht_next;
    logic                   w_unused_pc_bits;

    br_cond #(
        .XLEN (XLEN)
    ) u_br_cond (
        .i_funct3    (in_funct3),
        .i_op1       (in_op1),
        .i_op2       (in_op2),
        .o_take_c    (w_take),
        .o_illegal_c (w_illegal)
    );

    // Handshake: flush blocks acceptance so a same-cycle request is dropped.
    assign in_ready     = (!r_valid || out_ready) && !flush;
    assign w_accept     = in_valid && in_ready;
    assign w_update     = w_accept && !w_illegal;
    assign w_mispredict = !w_illegal && (w_take ^ in_pred_take);
    assign w_target     = w_take ? (in_pc + in_imm) : (in_pc + XLEN'(4));

    // Word-aligned PCs: index skips the two byte-offset bits.
    assign w_update_idx     = in_pc[IDX_W+1:2];
    assign w_lookup_idx     = pred_pc[IDX_W+1:2];
    assign w_unused_pc_bits = ^{pred_pc[XLEN-1:IDX_W+2], pred_pc[1:0]};

    // Lookup reads the stored counter, so a same-cycle update is not visible yet.
    assign pred_take = r_bht[w_lookup_idx][1];

    assign w_bht_cur = r_bht[w_update_idx];

    // Saturating 2-bit counter step.
    always_comb begin
        w_bht_next = w_bht_cur;
        if (w_take) begin
            if (w_bht_cur != CNT_MAX) begin
                w_bht_next = w_bht_cur + 2'd1;
            end
        end else begin
            if (w_bht_cur != CNT_MIN) begin
                w_bht_next = w_bht_cur - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid      <= 1'b0;
            r_take       <= 1'b0;
            r_mispredict <= 1'b0;
            r_illegal    <= 1'b0;
            r_target     <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid      <= 1'b1;
            r_take       <= w_take;
            r_mispredict <= w_mispredict;
            r_illegal    <= w_illegal;
            r_target     <= w_target;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
                r_bht[i] <= INIT_CNT;
            end
        end else if (w_update) begin
            r_bht[w_update_idx] <= w_bht_next;
        end
    end

    // Event counters wrap naturally at 2^32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt_branches <= '0;
            r_cnt_mispred  <= '0;
        end else if (w_update) begin
            r_cnt_branches <= r_cnt_branches + CNT_W'(1);
            if (w_mispredict) begin
                r_cnt_mispred <= r_cnt_mispred + CNT_W'(1);
            end
        end
    end

    assign out_valid      = r_valid;
    assign out_take       = r_take;
    assign out_mispredict = r_mispredict;
    assign out_illegal    = r_illegal;
    assign out_target     = r_target;
    assign cnt_branches   = r_cnt_branches;
    assign cnt_mispred    = r_cnt_mispred;

endmodule

// File: tb/tb_brunit_pipe.sv
// Self-checking bench for brunit_pipe: directed scenarios with literal expectations plus a
// randomized stream compared every cycle against a behavioural model of the branch unit.
module tb_brunit_pipe;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BHT  = 64;
    localparam int          INIT = 1;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [2:0]      in_funct3 = '0;
    logic [XLEN-1:0] in_op1 = '0;
    logic [XLEN-1:0] in_op2 = '0;
    logic [XLEN-1:0] in_pc = '0;
    logic [XLEN-1:0] in_imm = '0;
    logic            in_pred_take = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic            out_take;
    logic            out_mispredict;
    logic            out_illegal;
    logic [XLEN-1:0] out_target;
    logic            flush = 1'b0;
    logic [XLEN-1:0] pred_pc = '0;
    logic            pred_take;
    logic [31:0]     cnt_branches;
    logic [31:0]     cnt_mispred;

    always #5 clk = ~clk;

    brunit_pipe #(
        .XLEN        (XLEN),
        .BHT_ENTRIES (BHT),
        .INIT_CNT    (2'b01)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_funct3      (in_funct3),
        .in_op1         (in_op1),
        .in_op2         (in_op2),
        .in_pc          (in_pc),
        .in_imm         (in_imm),
        .in_pred_take   (in_pred_take),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_take       (out_take),
        .out_mispredict (out_mispredict),
        .out_illegal    (out_illegal),
        .out_target     (out_target),
        .flush          (flush),
        .pred_pc        (pred_pc),
        .pred_take      (pred_take),
        .cnt_branches   (cnt_branches),
        .cnt_mispred    (cnt_mispred)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_valid = 1'b0;
    logic        m_take = 1'b0;
    logic        m_misp = 1'b0;
    logic        m_ill = 1'b0;
    logic [31:0] m_target = '0;
    logic [31:0] m_cb = '0;
    logic [31:0] m_cm = '0;
    int          m_bht [BHT];
    logic        preload_req = 1'b0;

    function automatic int bidx(input logic [31:0] a);
        return int'((a >> 2) % BHT);
    endfunction

    // Returns {illegal, take} from the condition table.
    function automatic logic [1:0] ref_cond(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
        case (f3)
            3'd0: return {1'b0, a == b};
            3'd1: return {1'b0, a != b};
            3'd4: return {1'b0, $signed(a) <  $signed(b)};
            3'd5: return {1'b0, $signed(a) >= $signed(b)};
            3'd6: return {1'b0, a <  b};
            3'd7: return {1'b0, a >= b};
            default: return 2'b10;
        endcase
    endfunction

    always @(posedge clk or negedge rst or posedge preload_req) begin : model
        logic       rdy;
        logic [1:0] res;
        int         ix;
        if (!rst) begin
            m_valid = 1'b0; m_take = 1'b0; m_misp = 1'b0; m_ill = 1'b0;
            m_target = '0; m_cb = '0; m_cm = '0;
            foreach (m_bht[i]) m_bht[i] = INIT;
        end else if (preload_req) begin
            m_cb = 32'hFFFF_FFFF;
        end else begin
            rdy = (!m_valid || out_ready) && !flush;
            if (flush) begin
                m_valid = 1'b0;
            end else if (in_valid && rdy) begin
                res      = ref_cond(in_funct3, in_op1, in_op2);
                m_valid  = 1'b1;
                m_ill    = res[1];
                m_take   = res[0];
                m_misp   = !res[1] && (res[0] != in_pred_take);
                m_target = res[0] ? in_pc + in_imm : in_pc + 32'd4;
                if (!res[1]) begin
                    ix = bidx(in_pc);
                    m_bht[ix] = res[0] ? ((m_bht[ix] < 3) ? m_bht[ix] + 1 : 3)
                                       : ((m_bht[ix] > 0) ? m_bht[ix] - 1 : 0);
                    m_cb = m_cb + 32'd1;
                    if (m_misp) m_cm = m_cm + 32'd1;
                end
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // Every-cycle comparison, sampled on the falling edge.
    always @(negedge clk) begin
        chk("in_ready",       in_ready,       (!m_valid || out_ready) && !flush);
        chk("out_valid",      out_valid,      m_valid);
        chk("out_take",       out_take,       m_take);
        chk("out_mispredict", out_mispredict, m_misp);
        chk("out_illegal",    out_illegal,    m_ill);
        chk("out_target",     out_target,     m_target);
        chk("cnt_branches",   cnt_branches,   m_cb);
        chk("cnt_mispred",    cnt_mispred,    m_cm);
        chk("pred_take",      pred_take,      m_bht[bidx(pred_pc)] >= 2);
    end

    // ---------------- stimulus ----------------
    task automatic set_in(input logic v, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] pc, input logic [31:0] imm,
                          input logic pr, input logic ordy, input logic fl);
        in_valid = v; in_funct3 = f3; in_op1 = a; in_op2 = b; in_pc = pc; in_imm = imm;
        in_pred_take = pr; out_ready = ordy; flush = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_target", out_target, 0);
        chk("rst_cnt_branches", cnt_branches, 0);
        pred_pc = 32'h40;
        #1;
        chk("rst_bht_init", pred_take, 0);
        rst = 1'b1;
        tick();

        // Signed less-than, taken, mispredicted.
        set_in(1, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 0, 1, 0);
        tick();
        chk("blt_take", out_take, 1);
        chk("blt_target", out_target, 32'h120);
        chk("blt_misp", out_mispredict, 1);
        chk("blt_cnt_mispred", cnt_mispred, 1);

        // Unsigned less-than, same operands, not taken.
        set_in(1, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 0, 1, 0);
        tick();
        chk("bltu_take", out_take, 0);
        chk("bltu_target", out_target, 32'h104);
        chk("bltu_misp", out_mispredict, 0);
        chk("bltu_cnt_branches", cnt_branches, 2);

        // Backpressure: result frozen for 5 cycles.
        set_in(1, 3'b000, 32'd5, 32'd5, 32'h200, 32'h10, 1, 0, 0);
        #1;
        repeat (5) begin
            chk("hold_in_ready", in_ready, 0);
            tick();
            chk("hold_valid", out_valid, 1);
            chk("hold_target", out_target, 32'h104);
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", in_ready, 1);
        tick();
        chk("release_target", out_target, 32'h210);
        chk("release_misp", out_mispredict, 0);

        // Predictor training at pc 0x40; lookup sees the pre-update value.
        set_in(1, 3'b000, 32'd7, 32'd7, 32'h40, 32'h8, 0, 1, 0);
        pred_pc = 32'h40;
        #1;
        chk("bht_same_cycle", pred_take, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("bht_taken%0d", k), pred_take, 1);
        end
        pred_pc = 32'h140;
        #1;
        chk("bht_alias", pred_take, 1);
        set_in(1, 3'b001, 32'd7, 32'd7, 32'h40, 32'h8, 0, 1, 0);
        tick();
        chk("bht_nt1", pred_take, 1);
        tick();
        chk("bht_nt2", pred_take, 0);

        // Flush with a held result and a same-cycle request.
        set_in(0, 3'b000, 32'd0, 32'd0, 32'h0, 32'h0, 0, 0, 0);
        tick();
        chk("pre_flush_valid", out_valid, 1);
        set_in(1, 3'b000, 32'd3, 32'd3, 32'h40, 32'h4, 0, 0, 1);
        pred_pc = 32'h40;
        #1;
        chk("flush_in_ready", in_ready, 0);
        tick();
        chk("flush_valid", out_valid, 0);
        chk("flush_cnt_branches", cnt_branches, 9);
        chk("flush_cnt_mispred", cnt_mispred, 5);
        chk("flush_bht", pred_take, 0);

        // Counter wrap after preload.
        set_in(0, 3'b000, 32'd0, 32'd0, 32'h0, 32'h0, 0, 1, 0);
        tick();
        force dut.r_cnt_branches = 32'hFFFF_FFFF;
        preload_req = 1'b1;
        #1;
        release dut.r_cnt_branches;
        preload_req = 1'b0;
        #1;
        chk("preload", cnt_branches, 32'hFFFF_FFFF);
        set_in(1, 3'b000, 32'd1, 32'd2, 32'h80, 32'h4, 0, 1, 0);
        tick();
        set_in(0, 3'b000, 32'd0, 32'd0, 32'h0, 32'h0, 0, 1, 0);
        chk("cnt_wrap", cnt_branches, 0);

        // Random stream with a reset pulse in the middle.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a, b, pc;
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            pc = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_03FC);
            set_in($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), a, b, pc, $urandom,
                   1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7,
                   $urandom_range(0, 9) == 0);
            pred_pc = ($urandom & 32'h0000_03FC);
            if (i == 200) begin
                rst = 1'b0;
                #1;
                chk("midrst_valid", out_valid, 0);
                chk("midrst_take", out_take, 0);
                chk("midrst_misp", out_mispredict, 0);
                chk("midrst_illegal", out_illegal, 0);
                chk("midrst_target", out_target, 0);
                chk("midrst_cnt_branches", cnt_branches, 0);
                chk("midrst_cnt_mispred", cnt_mispred, 0);
                chk("midrst_bht", pred_take, 0);
                tick();
                tick();
                rst = 1'b1;
            end
            tick();
        end

        set_in(0, 3'b000, 32'd0, 32'd0, 32'h0, 32'h0, 0, 1, 0);
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
